// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline and the RV32M multiply/divide sequencer.
// The pipeline side uses the master modport; the sequencer uses slave.
interface ex_muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, flush_i,
    input  stall_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, flush_i,
    output stall_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// stalling the pipeline until a one-cycle valid pulse returns the result.
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter bit          FAST_DIV0 = 1'b1
) (
  input logic             clk_i,
  input logic             reset_i,
  ex_muldiv_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, s1, s2, sign1, sign2;
  logic              in_div0, in_ovf, fast;
  logic [XLEN-1:0]   preset, word_div;
  logic [XLEN:0]     sub_w, add_w;
  logic [2*XLEN-1:0] mul_fix;

  assign is_div = f3_q[2];
  assign s1     = (f3_q == 3'd1) || (f3_q == 3'd2) || (f3_q == 3'd4) || (f3_q == 3'd6);
  assign s2     = (f3_q == 3'd1) || (f3_q == 3'd4) || (f3_q == 3'd6);
  assign sign1  = s1 & op1_q[XLEN-1];
  assign sign2  = s2 & op2_q[XLEN-1];

  // Special divide cases are detected on the raw inputs so the fast path skips PREP.
  assign in_div0 = bus.funct3_i[2] & (bus.op2_i == '0);
  assign in_ovf  = bus.funct3_i[2] & ~bus.funct3_i[0] & (bus.op2_i == '1) &
                   (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}});
  assign fast    = FAST_DIV0 & (in_div0 | in_ovf);
  assign preset  = in_div0 ? (bus.funct3_i[1] ? bus.op1_i : '1)
                           : (bus.funct3_i[1] ? '0 : bus.op1_i);

  assign sub_w    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, op2_q};
  assign add_w    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op2_q} : '0);
  // High-word multiply results need the full-width negate, not a per-word one.
  assign mul_fix  = neg_q ? -acc_q : acc_q;
  assign word_div = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      f3_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.start_i) state_d = fast ? StDone : StPrep;
        StPrep:  state_d = StCalc;
        StCalc:  if (cnt_q == '0) state_d = StFix;
        StFix:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // op1_q doubles as the pending-result holder once the loop no longer needs it.
  always_comb begin
    f3_d     = f3_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i && !bus.flush_i) begin
          f3_d  = bus.funct3_i;
          op1_d = fast ? preset : bus.op1_i;
          op2_d = bus.op2_i;
        end
      end
      StPrep: begin
        op1_d = sign1 ? -op1_q : op1_q;
        op2_d = sign2 ? -op2_q : op2_q;
        acc_d = {{XLEN{1'b0}}, (sign1 ? -op1_q : op1_q)};
        cnt_d = CntW'(XLEN - 1);
        if (!is_div)      neg_d = sign1 ^ sign2;
        else if (f3_q[1]) neg_d = sign1;
        else              neg_d = (sign1 ^ sign2) & (op2_q != '0);
      end
      StCalc: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div) begin
          acc_d = sub_w[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {sub_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {add_w, acc_q[XLEN-1:1]};
        end
      end
      StFix: begin
        if (is_div)              op1_d = neg_q ? -word_div : word_div;
        else if (f3_q == 3'd0)   op1_d = mul_fix[XLEN-1:0];
        else                     op1_d = mul_fix[2*XLEN-1:XLEN];
      end
      StDone: begin
        if (!bus.flush_i) result_d = op1_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy_o   = (state_q != StIdle);
    bus.valid_o  = (state_q == StDone) & ~bus.flush_i;
    bus.result_o = bus.valid_o ? op1_q : result_q;
    // Reset forces every output low, including the stall request.
    bus.stall_o  = bus.start_i & ~bus.valid_o & ~bus.flush_i & reset_i;
  end
endmodule
